// File: rtl/wpat_pkg.sv
// Shared state, colour types and pattern helpers for the framebuffer pattern writer.
// The colour-bar pattern is selected in wpat_pixel_gen by defining WPAT_COLORBAR_EN.
package wpat_pkg;

    typedef enum logic [1:0] {IDLE, WRITE, DRAIN, DONE} state_t;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    localparam rgb_t C_WHITE   = 24'hFF_FFFF;
    localparam rgb_t C_YELLOW  = 24'hFF_FF00;
    localparam rgb_t C_CYAN    = 24'h00_FFFF;
    localparam rgb_t C_GREEN   = 24'h00_FF00;
    localparam rgb_t C_MAGENTA = 24'hFF_00FF;
    localparam rgb_t C_RED     = 24'hFF_0000;
    localparam rgb_t C_BLUE    = 24'h00_00FF;
    localparam rgb_t C_BLACK   = 24'h00_0000;

    // grid_mask is GRID-1; GRID is a power of two so the modulo reduces to a mask.
    function automatic logic [31:0] grid_pixel(input logic [15:0] x, input logic [15:0] y,
                                               input logic [15:0] grid_mask = 16'd15);
        return (((x & grid_mask) == 16'd0) || ((y & grid_mask) == 16'd0)) ?
               {8'h00, C_WHITE} : {8'h00, C_BLACK};
    endfunction

    function automatic rgb_t bar_colour(input logic [2:0] idx);
        case (idx)
            3'd0:    return C_WHITE;
            3'd1:    return C_YELLOW;
            3'd2:    return C_CYAN;
            3'd3:    return C_GREEN;
            3'd4:    return C_MAGENTA;
            3'd5:    return C_RED;
            3'd6:    return C_BLUE;
            default: return C_BLACK;
        endcase
    endfunction

endpackage

// File: rtl/wpat_pixel_gen.sv
// Raster x/y counters, byte offset and pattern colour for the current pixel.
// Define WPAT_COLORBAR_EN for eight vertical colour bars instead of the grid.
module wpat_pixel_gen
    import wpat_pkg::*;
#(
    parameter int HDISP = 800,
    parameter int VDISP = 480,
    parameter int GRID  = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        advance,
    output logic [31:0] pixel,
    output logic        last,
    output logic [31:0] offset
);

    localparam int XW = $clog2(HDISP + 1);
    localparam int YW = $clog2(VDISP + 1);

    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic          x_end;

    assign x_end = (x == XW'(HDISP - 1));
    assign last  = x_end && (y == YW'(VDISP - 1));

    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            x      <= '0;
            y      <= '0;
            offset <= '0;
        end else if (advance) begin
            offset <= last ? 32'd0 : offset + 32'd4;
            if (x_end) begin
                x <= '0;
                y <= last ? '0 : y + 1'b1;
            end else begin
                x <= x + 1'b1;
            end
        end
    end

`ifdef WPAT_COLORBAR_EN
    localparam int BW  = (HDISP >= 8) ? HDISP / 8 : 1;
    localparam int BCW = $clog2(BW + 1);

    logic [BCW-1:0] bar_cnt;
    logic [2:0]     bar_idx;

    // Bar position tracked by a width counter so no divider is needed.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            bar_cnt <= '0;
            bar_idx <= '0;
        end else if (advance) begin
            if (x_end) begin
                bar_cnt <= '0;
                bar_idx <= '0;
            end else if (bar_cnt == BCW'(BW - 1)) begin
                bar_cnt <= '0;
                if (bar_idx != 3'd7) bar_idx <= bar_idx + 3'd1;
            end else begin
                bar_cnt <= bar_cnt + 1'b1;
            end
        end
    end

    assign pixel = {8'h00, bar_colour(bar_idx)};
`else
    assign pixel = grid_pixel(16'(x), 16'(y), 16'(GRID - 1));
`endif

endmodule

// File: rtl/wb_pattern_writer.sv
// Wishbone B4 pipelined initiator that paints one test-pattern frame into the framebuffer.
// Pattern is a grid by default; WPAT_COLORBAR_EN selects colour bars in wpat_pixel_gen.
module wb_pattern_writer
    import wpat_pkg::*;
#(
    parameter int          HDISP     = 800,
    parameter int          VDISP     = 480,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          MAX_OUT   = 16,
    parameter int          GRID      = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        wb_cyc,
    output logic        wb_stb,
    output logic        wb_we,
    output logic [31:0] wb_adr,
    output logic [31:0] wb_dat_w,
    output logic [3:0]  wb_sel,
    output logic [2:0]  wb_cti,
    output logic [1:0]  wb_bte,
    input  logic        wb_ack,
    input  logic        wb_err,
    input  logic        wb_stall
);

    localparam int OW = $clog2(MAX_OUT) + 1;

    state_t        state, state_nxt;
    logic [OW-1:0] outst;
    logic [31:0]   pixel, offset;
    logic          last, accept, retire, launch;

    assign launch = (state == IDLE) && start;
    assign accept = wb_stb && !wb_stall;
    assign retire = wb_cyc && (wb_ack || wb_err) && (outst != '0);

    wpat_pixel_gen #(
        .HDISP (HDISP),
        .VDISP (VDISP),
        .GRID  (GRID)
    ) u_gen (
        .clk     (clk),
        .rst     (rst),
        .clear   (launch),
        .advance (accept),
        .pixel   (pixel),
        .last    (last),
        .offset  (offset)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // NOTE: every output gets a default before the case, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        wb_cyc    = (state == WRITE) || (state == DRAIN);
        wb_stb    = (state == WRITE) && (outst < OW'(MAX_OUT));
        wb_we     = wb_cyc;
        wb_adr    = wb_cyc ? BASE_ADDR + offset : 32'd0;
        wb_dat_w  = wb_cyc ? pixel : 32'd0;
        wb_sel    = wb_stb ? 4'hF : 4'h0;
        wb_cti    = 3'b000;
        wb_bte    = 2'b00;
        busy      = wb_cyc;
        done      = (state == DONE);
        unique case (state)
            IDLE:  if (start) state_nxt = WRITE;
            WRITE: if (accept && last) state_nxt = DRAIN;
            DRAIN: if (outst == '0) state_nxt = DONE;
            DONE:  state_nxt = IDLE;
        endcase
    end

    // Accept and retire in the same cycle cancel; a bus error still retires its write.
    always_ff @(posedge clk) begin
        if (rst) begin
            outst <= '0;
            err   <= 1'b0;
        end else if (launch) begin
            outst <= '0;
            err   <= 1'b0;
        end else begin
            if (accept && !retire)      outst <= outst + 1'b1;
            else if (retire && !accept) outst <= outst - 1'b1;
            if (wb_cyc && wb_err) err <= 1'b1;
        end
    end

    ack_needs_outstanding: assert property (@(posedge clk) disable iff (rst)
        (wb_cyc && (wb_ack || wb_err)) |-> (outst != '0));

endmodule

// File: doc/wb_pattern_writer.md
Name: wb_pattern_writer

Overview:
- Wishbone B4 pipelined initiator that fills the SDRAM framebuffer with a test pattern (one 32-bit word per pixel, raster order).
- It is the write side of the framebuffer; the VGA controller is the read side.
- Sits in Top next to the VGA controller, on the same wshb_if bus through the arbiter. Triggered once after reset, or on demand by a KEY/SW-derived pulse.

Parameters:
- HDISP, 800, active pixels per line.
- VDISP, 480, active lines per frame.
- BASE_ADDR, 32'h0000_0000, byte address of pixel (0,0).
- MAX_OUT, 16, maximum accepted-but-unacknowledged writes (power of 2, ≥2).
- GRID, 16, grid pitch in pixels (power of 2).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to paint a frame.
- busy  out  1  high while a frame is in progress.
- done  out  1  one-cycle pulse when the last ack is received.
- err  out  1  sticky; set by any wb_err, cleared by rst or by an accepted start.
- wb_cyc, wb_stb, wb_we  out  1 each.
- wb_adr  out  32  byte address.
- wb_dat_w  out  32  pixel, 8'h00 & R & G & B.
- wb_sel  out  4  always 4'hF while stb is high.
- wb_cti  out  3  always 3'b000.
- wb_bte  out  2  always 2'b00.
- wb_ack, wb_err, wb_stall  in  1 each.

Behaviour:
- Reset: state IDLE. busy=0, done=0, err=0, cyc=0, stb=0, we=0. adr and dat_w are 0. Pixel counters and the outstanding counter are 0.
- States:
  - IDLE: start=1 → WRITE (counters cleared, err cleared).
  - WRITE → DRAIN when the last pixel (x=HDISP-1, y=VDISP-1) is accepted.
  - DRAIN → DONE when the outstanding count is 0.
  - DONE → IDLE unconditionally after 1 cycle.
- busy=1 in WRITE and DRAIN. done=1 only in DONE.
- start is ignored outside IDLE.
- cyc=1 in WRITE and DRAIN. we=1 whenever cyc=1.
- stb=1 in WRITE only while outstanding < MAX_OUT. First stb rises one cycle after start is sampled.
- Handshake:
  - A write is accepted on a cycle with stb && !wb_stall.
  - On acceptance, adr, dat_w and the x/y counters advance on the next edge.
  - When stalled, adr and dat_w are held stable.
  - wb_ack or wb_err retires one outstanding write.
  - Accept and retire on the same cycle leave the count unchanged.
  - ack/err are ignored when cyc=0.
- Address: BASE_ADDR + 4*(y*HDISP + x). Implemented as an incrementing byte address (+4 per acceptance), with no multiplier.
- Counter wrap: x wraps at HDISP-1 to 0, incrementing y. The final acceptance at (HDISP-1, VDISP-1) stops issuing.
- Default pattern, grid:
  - pixel = 32'h00FF_FFFF if (x mod GRID == 0) or (y mod GRID == 0); else 32'h0000_0000.
  - Computed combinationally from the current counters.
- wb_err: counted as a retirement and sets err. Writing continues; the frame still completes with done.
- Outstanding counter width: $clog2(MAX_OUT)+1. Never exceeds MAX_OUT, never underflows. An ack with count 0 is a bus protocol violation, guarded by an assertion in simulation.
- Reset mid-frame: on the next edge cyc and stb drop and all state returns to reset values. No done pulse. Late acks are ignored.

Optional Feature:
- Macro: WPAT_COLORBAR_EN.
- Defined: pattern is 8 vertical colour bars, each HDISP/8 wide. Bar index = x / (HDISP/8), selecting in order white, yellow, cyan, green, magenta, red, blue, black (FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000). Bar width is tracked by a secondary counter, not a divider.
- Undefined: grid pattern as above.
- Handshake and timing are identical in both builds.

Decomposition:
- Package wpat_pkg:
  - typedef state_t {IDLE, WRITE, DRAIN, DONE}.
  - typedef rgb_t (3×8-bit struct).
  - Localparams for the colour constants.
  - Function grid_pixel(x, y).
- Sub-module wpat_pixel_gen: x/y raster counters plus pattern colour. Takes an advance input; outputs pixel, last and byte offset.
- Top-level FSM, outstanding counter and Wishbone drive remain in wb_pattern_writer.

Test Plan:
- Test parameters HDISP=4, VDISP=3, GRID=2, MAX_OUT=4, BASE_ADDR=32'h100. Slave never stalls, acks 1 cycle after acceptance. Pulse start → exactly 12 writes at addresses 0x100..0x12C step 4; pixel(1,1)=0, pixel(2,0)=00FFFFFF; done pulses once; busy spans first stb to done.
- Slave stalls 3 cycles on the 5th write → adr=0x110 and its data held stable while stalled; total writes still 12; no address skipped.
- Slave withholds acks → stb drops after 4 acceptances (outstanding=4); resumes one cycle after the first ack.
- Slave returns wb_err on write 7 → err=1 after that cycle, remains 1 after done; next start clears it.
- rst asserted during write 6 → next edge cyc=0, stb=0, busy=0, no done. A following start repaints from 0x100.
- start asserted while busy → ignored; exactly one done and 12 writes.
